// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding req/ack access per instruction on a word-addressed data port.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter logic [31:0] RESET_LOAD_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic        one_op;
    logic        trap;
    logic        accept;
    logic [3:0]  be_lanes;
    logic [31:0] wdata_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    assign one_op = load ^ store;
    assign accept = (state == S_IDLE) && start;

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = one_op && (((funct3[1:0] == 2'b01) && addr[0]) ||
                             (funct3[1] && (addr[1:0] != 2'b00)));

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= trap;
        end
    end
`else
    assign trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: no-ops and trapped accesses skip straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (one_op && !trap) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Request operands are captured once so the memory port stays stable during REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= 32'h0;
            sd_q      <= 32'h0;
            f3_q      <= 3'b000;
            st_q      <= 1'b0;
            load_data <= RESET_LOAD_DATA;
        end else begin
            if (accept) begin
                addr_q <= addr;
                sd_q   <= store_data;
                f3_q   <= funct3;
                st_q   <= store;
            end
            if ((state == S_REQ) && mem_ack && !st_q) begin
                load_data <= rd_ext;
            end
        end
    end

    // Store lane placement; funct3[1:0]=11 falls through to word
    always_comb begin
        be_lanes    = 4'b1111;
        wdata_lanes = sd_q;
        case (f3_q[1:0])
            2'b00: begin
                be_lanes    = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{sd_q[7:0]}};
            end
            2'b01: begin
                be_lanes    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{sd_q[15:0]}};
            end
            default: begin
                be_lanes    = 4'b1111;
                wdata_lanes = sd_q;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_ext = {24'h0, rd_byte};
            3'b101:  rd_ext = {16'h0, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    // Memory handshake: mem_req is held with we/addr/be/wdata stable until the
    // cycle mem_ack is high; that cycle completes the access. No back-to-back reqs.
    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mem_req    = (state == S_REQ);
        mem_we     = (state == S_REQ) && st_q;
        mem_be     = ((state == S_REQ) && st_q) ? be_lanes : 4'b0000;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_lanes;
        state_dbg  = state;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (state == S_DONE) && mis_q;
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: request and completion scoreboards fed by the driver, checked by monitors.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // done entries: {cycle[30:0], misaligned, load_data}
    logic [63:0] exp_q[$];
    // request entries: {3'b0, we, addr, be, wdata}
    logic [71:0] exp_req_q[$];
    logic [63:0] done_e;
    logic [71:0] req_e;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load       (load),
        .store      (store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 32'h0);
            end else begin
                done_e = exp_q.pop_front();
                check("done_cycle", cyc, {1'b0, done_e[63:33]});
                check("load_data", load_data, done_e[31:0]);
                check("misaligned", {31'b0, misaligned}, {31'b0, done_e[32]});
                check("busy_in_done", {31'b0, busy}, 32'h1);
                check("no_req_in_done", {31'b0, mem_req}, 32'h0);
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            if (exp_req_q.size() == 0) begin
                check("unexpected_req", {31'b0, mem_req}, 32'h0);
            end else begin
                req_e = exp_req_q[0];
                check("req_we", {31'b0, mem_we}, {31'b0, req_e[68]});
                check("req_addr", mem_addr, req_e[67:36]);
                check("req_be", {28'b0, mem_be}, {28'b0, req_e[35:32]});
                if (req_e[68]) check("req_wdata", mem_wdata, req_e[31:0]);
                check("busy_in_req", {31'b0, busy}, 32'h1);
                if (mem_ack === 1'b1) void'(exp_req_q.pop_front());
            end
        end
    end

    // Driver: start in cycle 0, ack in REQ cycle r, optional second start while busy
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                           input int r, input logic exp_req, input logic exp_we,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_ld,
                           input logic exp_mis, input logic dbl);
        int dc;
        @(negedge clk);
        start      = 1'b1;
        load       = ld;
        store      = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        if (exp_req) exp_req_q.push_back({3'b0, exp_we, exp_addr, exp_be, exp_wd});
        dc = cyc + (exp_req ? r + 1 : 1);
        exp_q.push_back({dc[30:0], exp_mis, exp_ld});
        if (exp_req) begin
            for (int k = 1; k <= r; k++) begin
                @(negedge clk);
                start      = dbl && (k == 1);
                load       = 1'b1;
                store      = 1'b0;
                funct3     = 3'b010;
                addr       = 32'hFFFF_FFF0;
                store_data = 32'h0BAD_0BAD;
                mem_ack    = (k == r);
                mem_rdata  = (k == r) ? rd : 32'hDEAD_0000;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("idle_busy", {31'b0, busy}, 32'h0);
        check("idle_load_data", load_data, exp_ld);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        load       = 1'b0;
        store      = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        store_data = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_be", {28'b0, mem_be}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check("rst_state", {30'b0, state_dbg}, 32'h0);
        rst = 1'b0;

        // LB / LBU from lane 3, ack in first REQ cycle
        run_txn(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1, 1, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 0);
        run_txn(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1, 1, 0, 32'h100, 4'b0000, 32'h0, 32'h0000_0080, 0, 0);
        // SH upper half, req held 3 cycles, load_data untouched
        run_txn(0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF, 32'h0, 3, 1, 1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080, 0, 0);
        // LW with a second start while busy
        run_txn(1, 0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 2, 1, 0, 32'h40, 4'b0000, 32'h0, 32'h1234_5678, 0, 1);
        // No-ops: neither and both op bits
        run_txn(0, 0, 3'b010, 32'h44, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h1234_5678, 0, 0);
        run_txn(1, 1, 3'b010, 32'h48, 32'h0, 32'h0, 0, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h1234_5678, 0, 0);
        // LH upper lane sign-extended, LHU lower lane zero-extended
        run_txn(1, 0, 3'b001, 32'h6, 32'h0, 32'h8001_7FFF, 1, 1, 0, 32'h4, 4'b0000, 32'h0, 32'hFFFF_8001, 0, 0);
        run_txn(1, 0, 3'b101, 32'h4, 32'h0, 32'h8001_F00D, 1, 1, 0, 32'h4, 4'b0000, 32'h0, 32'h0000_F00D, 0, 0);
        // SB lane 2 and SW
        run_txn(0, 1, 3'b000, 32'h302, 32'h1234_56A5, 32'h0, 2, 1, 1, 32'h300, 4'b0100, 32'hA5A5_A5A5, 32'h0000_F00D, 0, 0);
        run_txn(0, 1, 3'b010, 32'h1000, 32'hCAFE_F00D, 32'h0, 1, 1, 1, 32'h1000, 4'b1111, 32'hCAFE_F00D, 32'h0000_F00D, 0, 0);
        // LB positive byte from lane 1
        run_txn(1, 0, 3'b000, 32'h1, 32'h0, 32'h0000_7F00, 1, 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0000_007F, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        run_txn(1, 0, 3'b010, 32'h41, 32'h0, 32'hA5A5_0001, 1, 0, 0, 32'h0, 4'b0000, 32'h0, 32'h0000_007F, 1, 0);
`else
        run_txn(1, 0, 3'b010, 32'h41, 32'h0, 32'hA5A5_0001, 1, 1, 0, 32'h40, 4'b0000, 32'h0, 32'hA5A5_0001, 0, 0);
`endif

        // Reset during REQ, then a late ack
        @(negedge clk);
        start  = 1'b1;
        load   = 1'b1;
        store  = 1'b0;
        funct3 = 3'b010;
        addr   = 32'h80;
        exp_req_q.push_back({3'b0, 1'b0, 32'h80, 4'b0000, 32'h0});
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        void'(exp_req_q.pop_front());
        #1;
        check("midrst_req", {31'b0, mem_req}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_wdata", mem_wdata, 32'h0);
        check("midrst_be", {28'b0, mem_be}, 32'h0);
        check("midrst_state", {30'b0, state_dbg}, 32'h0);
        check("midrst_load_data", load_data, 32'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("late_ack_done", {31'b0, done}, 32'h0);
        check("late_ack_busy", {31'b0, busy}, 32'h0);
        check("late_ack_load_data", load_data, 32'h0);

        repeat (3) @(negedge clk);
        #2;
        check("done_queue_empty", exp_q.size(), 32'h0);
        check("req_queue_empty", exp_req_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
